// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control block.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_BOOT     = 2'd0,
        PC_RUN      = 2'd1,
        PC_MEM_WAIT = 2'd2
    } pc_state_t;

    localparam int MEM_LAT_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {CNT_W{1'b1}}))
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Load/clear sequencing for PC and the four stage registers: memory stall,
// branch flush and hazard bubble arbitration, plus stall/flush statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             mem_req,
    input  logic             br_taken,
    input  logic             hazard,
    input  logic             clr_cnt,
    output logic             pc_ld,
    output logic             if_id_ld,
    output logic             id_ex_ld,
    output logic             ex_mem_ld,
    output logic             mem_wb_ld,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             ex_mem_clr,
    output logic             mem_wb_clr,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pc_state_t        state, nxt;
    logic [LAT_W-1:0] wcnt, wnxt;
    logic [4:0]       ld;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [3:0]       clr;   // {if_id, id_ex, ex_mem, mem_wb}
    logic             adv;
    logic             stall_inc, flush_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PC_BOOT;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            wcnt  <= wnxt;
        end
    end

    always_comb begin
        nxt      = state;
        wnxt     = wcnt;
        ld       = '0;
        clr      = '0;
        mem_done = 1'b0;
        adv      = 1'b0;
        unique case (state)
            PC_BOOT: begin
                clr = '1;
                nxt = PC_RUN;
            end
            PC_RUN: begin
                if (!halt) begin
                    if ((MEM_LAT > 0) && mem_req) begin
                        wnxt = LAT_W'(MEM_LAT - 1);
                        nxt  = PC_MEM_WAIT;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            PC_MEM_WAIT: begin
                if (!halt) begin
                    if (wcnt != '0) begin
                        wnxt = wcnt - LAT_W'(1);
                    end else begin
                        mem_done = 1'b1;
                        adv      = 1'b1;
                        nxt      = PC_RUN;
                    end
                end
            end
            default: nxt = PC_BOOT;
        endcase
        // Advance cycle: branch flush beats hazard bubble beats plain advance.
        if (adv) begin
            if (br_taken) begin
                ld  = '1;
                clr = 4'b1100;
            end else if (hazard) begin
                ld  = 5'b00111;
                clr = 4'b0100;
            end else begin
                ld  = '1;
            end
        end
    end

    assign {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld} = ld;
    assign {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}    = clr;

    assign stall_inc = (state != PC_BOOT) && !halt && !ld[4];
    assign flush_inc = adv && br_taken;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (clr_cnt),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .clr (clr_cnt),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven bench for pipe_ctrl with a scoreboard queue of expected outputs.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halt = 1'b0, mem_req = 1'b0, br_taken = 1'b0, hazard = 1'b0, clr_cnt = 1'b0;

    logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
    logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, mem_done;
    logic [15:0] stall_cnt, flush_cnt;

    logic b_pc_ld, b_if_id_ld, b_id_ex_ld, b_ex_mem_ld, b_mem_wb_ld;
    logic b_if_id_clr, b_id_ex_clr, b_ex_mem_clr, b_mem_wb_clr, b_mem_done;
    logic [1:0] b_stall_cnt, b_flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_LAT(4), .LAT_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .halt(halt), .mem_req(mem_req), .br_taken(br_taken),
        .hazard(hazard), .clr_cnt(clr_cnt),
        .pc_ld(pc_ld), .if_id_ld(if_id_ld), .id_ex_ld(id_ex_ld), .ex_mem_ld(ex_mem_ld),
        .mem_wb_ld(mem_wb_ld), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
        .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr), .mem_done(mem_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy, driven by the same stimulus, to exercise saturation.
    pipe_ctrl #(.MEM_LAT(4), .LAT_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .halt(halt), .mem_req(mem_req), .br_taken(br_taken),
        .hazard(hazard), .clr_cnt(clr_cnt),
        .pc_ld(b_pc_ld), .if_id_ld(b_if_id_ld), .id_ex_ld(b_id_ex_ld), .ex_mem_ld(b_ex_mem_ld),
        .mem_wb_ld(b_mem_wb_ld), .if_id_clr(b_if_id_clr), .id_ex_clr(b_id_ex_clr),
        .ex_mem_clr(b_ex_mem_clr), .mem_wb_clr(b_mem_wb_clr), .mem_done(b_mem_done),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    typedef struct {
        string      name;
        bit         boot, h, m, br, hz, cc;
        logic [4:0] ld;
        logic [3:0] cl;
        logic       done;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  ld;
        logic [3:0]  cl;
        logic        done;
        logic [15:0] st, fl;
        logic [1:0]  st2, fl2;
    } exp_t;

    localparam logic [4:0] L0 = 5'b00000, L1 = 5'b11111, LH = 5'b00111;
    localparam logic [3:0] C0 = 4'b0000, CB = 4'b1111, CF = 4'b1100, CH = 4'b0100;

    vec_t  tbl[$];
    exp_t  sb[$];
    int    ncmp = 0, nbad = 0;
    logic [15:0] m_st = '0, m_fl = '0;
    logic [1:0]  m_st2 = '0, m_fl2 = '0;

    function automatic vec_t mk(string n, bit b, bit h, bit m, bit br, bit hz, bit cc,
                                logic [4:0] l, logic [3:0] c, logic d);
        vec_t v;
        v.name = n; v.boot = b; v.h = h; v.m = m; v.br = br; v.hz = hz; v.cc = cc;
        v.ld = l; v.cl = c; v.done = d;
        return v;
    endfunction

    task automatic compare_out();
        exp_t e;
        logic [4:0] a_ld;
        logic [3:0] a_cl;
        e = sb.pop_front();
        a_ld = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld};
        a_cl = {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr};
        ncmp++;
        if (a_ld !== e.ld || a_cl !== e.cl || mem_done !== e.done || stall_cnt !== e.st ||
            flush_cnt !== e.fl || b_stall_cnt !== e.st2 || b_flush_cnt !== e.fl2) begin
            nbad++;
            $display("FAIL %s: got ld=%b clr=%b done=%b stall=%0d flush=%0d stall2=%0d flush2=%0d; want ld=%b clr=%b done=%b stall=%0d flush=%0d stall2=%0d flush2=%0d",
                     e.name, a_ld, a_cl, mem_done, stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt,
                     e.ld, e.cl, e.done, e.st, e.fl, e.st2, e.fl2);
        end
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic apply(input vec_t v);
        exp_t e;
        halt = v.h; mem_req = v.m; br_taken = v.br; hazard = v.hz; clr_cnt = v.cc;
        e.name = v.name; e.ld = v.ld; e.cl = v.cl; e.done = v.done;
        e.st = m_st; e.fl = m_fl; e.st2 = m_st2; e.fl2 = m_fl2;
        sb.push_back(e);
        if (v.cc) begin
            m_st = '0; m_fl = '0; m_st2 = '0; m_fl2 = '0;
        end else if (!v.boot && !v.h) begin
            if (!v.ld[4]) begin
                if (m_st != 16'hFFFF) m_st++;
                if (m_st2 != 2'b11) m_st2++;
            end
            if (v.cl[3]) begin
                if (m_fl != 16'hFFFF) m_fl++;
                if (m_fl2 != 2'b11) m_fl2++;
            end
        end
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the reset outputs, releases it after the next edge.
    task automatic do_reset(input string n);
        halt = 1'b0; mem_req = 1'b0; br_taken = 1'b0; hazard = 1'b0; clr_cnt = 1'b0;
        rst = 1'b0;
        m_st = '0; m_fl = '0; m_st2 = '0; m_fl2 = '0;
        sb.push_back('{n, L0, CB, 1'b0, 16'd0, 16'd0, 2'd0, 2'd0});
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Build the main vector table.
        tbl.push_back(mk("t1_boot",      1, 1, 0, 0, 0, 0, L0, CB, 0));
        tbl.push_back(mk("t1_run",       0, 0, 0, 0, 0, 0, L1, C0, 0));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk("t2_mem_start", 0, 0, 1, 0, 0, 0, L0, C0, 0));
            for (int w = 0; w < 3; w++)
                tbl.push_back(mk("t2_mem_wait", 0, 0, 1, 0, 0, 0, L0, C0, 0));
            tbl.push_back(mk("t2_mem_done", 0, 0, 1, 0, 0, 0, L1, C0, 1));
        end
        tbl.push_back(mk("t2_idle",      0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("t3_hazard",    0, 0, 0, 0, 1, 0, LH, CH, 0));
        tbl.push_back(mk("t3_hazard",    0, 0, 0, 0, 1, 0, LH, CH, 0));
        tbl.push_back(mk("t3_idle",      0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("t4_br_hz",     0, 0, 0, 1, 1, 0, L1, CF, 0));
        tbl.push_back(mk("t4_idle",      0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("t5_mem_br",    0, 0, 1, 1, 0, 0, L0, C0, 0));
        for (int w = 0; w < 3; w++)
            tbl.push_back(mk("t5_wait_br", 0, 0, 0, 1, 0, 0, L0, C0, 0));
        tbl.push_back(mk("t5_done_br",   0, 0, 0, 1, 0, 0, L1, CF, 1));
        tbl.push_back(mk("t5_idle",      0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("halt_run",     0, 1, 1, 1, 1, 0, L0, C0, 0));
        tbl.push_back(mk("halt_after",   0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("halt_mem",     0, 0, 1, 0, 0, 0, L0, C0, 0));
        tbl.push_back(mk("halt_wait",    0, 1, 0, 0, 0, 0, L0, C0, 0));
        tbl.push_back(mk("halt_wait",    0, 1, 0, 0, 0, 0, L0, C0, 0));
        for (int w = 0; w < 3; w++)
            tbl.push_back(mk("halt_resume", 0, 0, 0, 0, 0, 0, L0, C0, 0));
        tbl.push_back(mk("halt_done",    0, 0, 0, 0, 0, 0, L1, C0, 1));
        tbl.push_back(mk("hz_mem",       0, 0, 1, 0, 1, 0, L0, C0, 0));
        for (int w = 0; w < 3; w++)
            tbl.push_back(mk("hz_wait",  0, 0, 0, 0, 1, 0, L0, C0, 0));
        tbl.push_back(mk("hz_done",      0, 0, 0, 0, 1, 0, LH, CH, 1));
        tbl.push_back(mk("t6_clr",       0, 0, 0, 0, 0, 1, L1, C0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk("t6_hazard", 0, 0, 0, 0, 1, 0, LH, CH, 0));
        tbl.push_back(mk("t6_hz_clr",    0, 0, 0, 0, 1, 1, LH, CH, 0));
        tbl.push_back(mk("t6_after_clr", 0, 0, 0, 0, 0, 0, L1, C0, 0));
        tbl.push_back(mk("t6_idle",      0, 0, 0, 0, 0, 0, L1, C0, 0));

        @(posedge clk);
        #1;
        do_reset("t1_in_reset");
        foreach (tbl[i]) apply(tbl[i]);

        // Reset in the middle of a memory wait discards the pending access.
        apply(mk("rst_mem",   0, 0, 1, 0, 0, 0, L0, C0, 0));
        apply(mk("rst_wait",  0, 0, 0, 0, 0, 0, L0, C0, 0));
        do_reset("rst_mid_wait");
        apply(mk("rst_boot",  1, 0, 0, 0, 0, 0, L0, CB, 0));
        apply(mk("rst_run",   0, 0, 0, 0, 0, 0, L1, C0, 0));
        apply(mk("rst_mem2",  0, 0, 1, 0, 0, 0, L0, C0, 0));
        for (int w = 0; w < 3; w++)
            apply(mk("rst_wait2", 0, 0, 0, 0, 0, 0, L0, C0, 0));
        apply(mk("rst_done2", 0, 0, 0, 0, 0, 0, L1, C0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
